// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect sequencer for the five-stage pipeline (build option: FORWARDING_EN).
// Latency: zero cycles, so a hazard seen in cycle N stalls the PC and IF2ID in cycle N. busy is registered.
// Backpressure: PC_En and IF2ID_En are held low for 1 or 2 cycles per hazard. ex_redirect overrides any stall.
module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_Reg_W_En,
  input  logic                   ex_Mem_R_En,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_Reg_W_En,
  input  logic                   ex_redirect,
  input  logic                   perf_clr,
  output logic                   PC_En,
  output logic                   IF2ID_En,
  output logic                   IF2ID_Flush,
  output logic                   ID2EXE_Flush,
  output logic                   stall_twice,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    STALL1 = 1'b1
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = FLUSH_CNT_W'(1);

  state_t     state;
  logic       busy_q;
  logic       ex_hit;
  logic [1:0] depth;
  logic       stall;
  logic       stall_two;

  // An EX producer matches when it writes a non-zero rd that the ID instruction reads.
  assign ex_hit = ex_Reg_W_En && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef FORWARDING_EN
  // With forwarding, ALU results reach ID in time. MEM producers are never consulted.
  logic unused_mem_inputs;
  assign unused_mem_inputs = ^{mem_rd, mem_Reg_W_En};

  // Only a load in EX is too late to forward, and it costs one bubble.
  always_comb begin
    depth = 2'd0;
    if (ex_hit && ex_Mem_R_En) begin
      depth = 2'd1;
    end
  end
`else
  logic mem_hit;
  logic unused_load_flag;

  // Without forwarding the load flag is irrelevant. Any EX or MEM producer must drain first.
  assign unused_load_flag = ex_Mem_R_En;

  // A MEM producer matches under the same conditions as an EX producer.
  assign mem_hit = mem_Reg_W_En && (mem_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == mem_rd)) ||
                    (id_use_rs2 && (id_rs2 == mem_rd)));

  // EX producer needs two bubbles and MEM producer one. WB is covered by the write-first regfile.
  always_comb begin
    depth = 2'd0;
    if (ex_hit) begin
      depth = 2'd2;
    end else if (mem_hit) begin
      depth = 2'd1;
    end
  end
`endif

  // Decide whether this cycle is a stall. A redirect or reset suppresses any stall.
  always_comb begin
    stall     = 1'b0;
    stall_two = 1'b0;
    if (!Reset && !ex_redirect) begin
      if (state == STALL1) begin
        stall = 1'b1;
      end else if (depth != 2'd0) begin
        stall     = 1'b1;
        stall_two = (depth == 2'd2);
      end
    end
  end

  // Pipeline controls are combinational from state and the current inputs.
  always_comb begin
    PC_En        = !stall;
    IF2ID_En     = !stall;
    IF2ID_Flush  = !Reset && ex_redirect;
    ID2EXE_Flush = !Reset && (ex_redirect || stall);
    stall_twice  = stall_two;
    busy         = busy_q && !Reset;
  end

  // Stall sequencer. busy is registered alongside the state it mirrors.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else if (ex_redirect) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (depth == 2'd2) begin
            state  <= STALL1;
            busy_q <= 1'b1;
          end
        end
        STALL1: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen. A clear beats an increment.
  always_ff @(posedge clk) begin
    if (Reset || perf_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

  // Saturating count of redirects taken. A clear beats an increment.
  always_ff @(posedge clk) begin
    if (Reset || perf_clr) begin
      flush_count <= '0;
    end else if (ex_redirect && (flush_count != '1)) begin
      flush_count <= flush_count + FLUSH_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
// Control vectors are written by hand. Counter expectations come from the hand-written PC_En and redirect columns.
module tb_pipe_hazard_ctrl;
  localparam int SCW = 3;
  localparam int FCW = 2;

  // {PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_Flush, stall_twice, busy}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] STL  = 6'b000100;
  localparam logic [5:0] ST2  = 6'b000110;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] RDR  = 6'b111100;
  localparam logic [5:0] RDRB = 6'b111101;

`ifdef FORWARDING_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           Reset;
  logic [4:0]     id_rs1, id_rs2, ex_rd, mem_rd;
  logic           id_use_rs1, id_use_rs2, ex_Reg_W_En, ex_Mem_R_En, mem_Reg_W_En;
  logic           ex_redirect, perf_clr;
  logic           PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_Flush, stall_twice, busy;
  logic [SCW-1:0] stall_cycles;
  logic [FCW-1:0] flush_count;

  pipe_hazard_ctrl #(.STALL_CNT_W(SCW), .FLUSH_CNT_W(FCW)) dut (
    .clk(clk), .Reset(Reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_Reg_W_En(ex_Reg_W_En), .ex_Mem_R_En(ex_Mem_R_En),
    .mem_rd(mem_rd), .mem_Reg_W_En(mem_Reg_W_En),
    .ex_redirect(ex_redirect), .perf_clr(perf_clr),
    .PC_En(PC_En), .IF2ID_En(IF2ID_En), .IF2ID_Flush(IF2ID_Flush),
    .ID2EXE_Flush(ID2EXE_Flush), .stall_twice(stall_twice), .busy(busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct {
    string          nm;
    logic [5:0]     ctl;
    bit             cnt_chk;
    logic [SCW-1:0] sc;
    logic [FCW-1:0] fc;
  } exp_t;

  exp_t           sb[$];
  exp_t           cur;
  int             errors = 0;
  int             checks = 0;
  logic [SCW-1:0] m_sc = '0;
  logic [FCW-1:0] m_fc = '0;
  bit             m_known = 1'b0;

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", what, got, want);
    end
  endtask

  // Queue the expected response for the current cycle, then advance the counter model.
  task automatic exp_cyc(input string nm, input logic [5:0] ctl);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.cnt_chk = m_known; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (Reset) begin
      m_sc = '0; m_fc = '0; m_known = 1'b1;
    end else if (perf_clr) begin
      m_sc = '0; m_fc = '0;
    end else begin
      if (!ctl[5] && (m_sc != '1)) m_sc = m_sc + SCW'(1);
      if (ex_redirect && (m_fc != '1)) m_fc = m_fc + FCW'(1);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_Reg_W_En = 1'b0; ex_Mem_R_En = 1'b0;
    mem_rd = 5'd0; mem_Reg_W_En = 1'b0; ex_redirect = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic load_x3();
    clr_in();
    ex_rd = 5'd3; ex_Reg_W_En = 1'b1; ex_Mem_R_En = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
  endtask

  // Monitor: every cycle presents a control vector, compared mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk({cur.nm, ".ctl"}, 32'({PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_Flush, stall_twice, busy}),
            32'(cur.ctl));
        if (cur.cnt_chk) begin
          chk({cur.nm, ".stall_cycles"}, 32'(stall_cycles), 32'(cur.sc));
          chk({cur.nm, ".flush_count"}, 32'(flush_count), 32'(cur.fc));
        end
      end
    end
  end

  initial begin
    clr_in();
    Reset = 1'b1;
    nxt();
    // Reset dominates a redirect and a live hazard.
    ex_redirect = 1'b1; ex_rd = 5'd5; ex_Reg_W_En = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    exp_cyc("rst_a", NORM);
    nxt(); exp_cyc("rst_b", NORM);
    nxt(); Reset = 1'b0; clr_in(); exp_cyc("post_rst", NORM);

    // EX producer without a load. Inputs are held through the stall.
    nxt(); ex_rd = 5'd5; ex_Reg_W_En = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    exp_cyc("ex_h1", FW ? NORM : ST2);
    nxt(); exp_cyc("ex_h2", FW ? NORM : STB);
    nxt(); clr_in(); exp_cyc("ex_done", NORM);

    // MEM-only producer.
    nxt(); mem_rd = 5'd7; mem_Reg_W_En = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    exp_cyc("mem_h", FW ? NORM : STL);
    nxt(); clr_in(); exp_cyc("mem_done", NORM);

    // x0 never hazards, unused sources never hazard, and a producer without write enable is ignored.
    nxt(); mem_rd = 5'd0; mem_Reg_W_En = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    ex_rd = 5'd0; ex_Reg_W_En = 1'b1; ex_Mem_R_En = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    exp_cyc("x0", NORM);
    nxt(); clr_in(); ex_rd = 5'd5; ex_Reg_W_En = 1'b1; ex_Mem_R_En = 1'b1; id_rs1 = 5'd5;
    mem_rd = 5'd6; mem_Reg_W_En = 1'b1; id_rs2 = 5'd6;
    exp_cyc("nouse", NORM);
    nxt(); clr_in(); ex_rd = 5'd5; ex_Mem_R_En = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    exp_cyc("no_wen", NORM);

    // A load in EX to x3. The second no-forwarding cycle ignores the cleared inputs.
    nxt(); load_x3(); exp_cyc("ld_1", FW ? STL : ST2);
    nxt(); clr_in(); exp_cyc("ld_2", FW ? NORM : STB);
    nxt(); exp_cyc("ld_3", NORM);

    // A redirect in the same cycle as a hazard wins and is not counted as a stall.
    nxt(); load_x3(); ex_redirect = 1'b1; exp_cyc("rdr_haz", RDR);
    nxt(); clr_in(); exp_cyc("rdr_after", NORM);

    // A redirect in the second stall cycle aborts the stall.
    nxt(); load_x3(); exp_cyc("rdr_s1a", FW ? STL : ST2);
    nxt(); ex_redirect = 1'b1; exp_cyc("rdr_s1b", FW ? RDR : RDRB);
    nxt(); clr_in(); exp_cyc("rdr_s1c", NORM);

    // Reset in the middle of a stall leaves no residual stall.
    nxt(); load_x3(); exp_cyc("rmid_a", FW ? STL : ST2);
    nxt(); Reset = 1'b1; exp_cyc("rmid_b", NORM);
    nxt(); Reset = 1'b0; clr_in(); exp_cyc("rmid_c", NORM);

    // Back-to-back single stalls drive stall_cycles into saturation at 7.
    for (int i = 0; i < 10; i++) begin
      nxt(); clr_in();
      if (FW) load_x3();
      else begin mem_rd = 5'd7; mem_Reg_W_En = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; end
      perf_clr = (i == 9);
      exp_cyc($sformatf("sat%0d", i), STL);
    end
    nxt(); clr_in(); exp_cyc("sat_clr", NORM);

    // Five redirects saturate flush_count at 3.
    for (int i = 0; i < 5; i++) begin
      nxt(); clr_in(); ex_redirect = 1'b1; exp_cyc($sformatf("fsat%0d", i), RDR);
    end
    nxt(); clr_in(); exp_cyc("fsat_end", NORM);
    nxt(); exp_cyc("final", NORM);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and redirect sequencer for the five-stage pipeline. It sits beside the ID stage and compares the ID instruction's source registers against the destinations in EX and MEM. It drives the PC and IF2ID enables, flushes IF2ID and ID2EXE, and emits the `stall_twice` pulse consumed by EXE2MEM. It owns the stall state machine and two saturating performance counters.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the stall-cycle counter.
- `FLUSH_CNT_W`, default 16: width of the flush counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `id_rs1`, `id_rs2`  in  5 each  source register fields of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_Reg_W_En`, `ex_Mem_R_En`  in  1 each  EX writes a register / EX is a load.
- `mem_rd`  in  5  destination register of the MEM instruction.
- `mem_Reg_W_En`  in  1  MEM writes a register.
- `ex_redirect`  in  1  taken branch or jump resolved in EX this cycle.
- `perf_clr`  in  1  synchronous clear of both counters.
- `PC_En`, `IF2ID_En`  out  1 each  PC and IF2ID load enables.
- `IF2ID_Flush`, `ID2EXE_Flush`  out  1 each  insert a bubble into that register.
- `stall_twice`  out  1  one-cycle pulse marking the start of a two-cycle stall.
- `busy`  out  1  state is not IDLE.
- `stall_cycles`  out  `STALL_CNT_W`  cycles with `PC_En`=0.
- `flush_count`  out  `FLUSH_CNT_W`  number of redirects taken.

## Operation
- A source matches a producer when all of these hold: `id_use_rsN`=1, `id_rsN`==rd, the producer's write enable is 1, and rd≠0. x0 never causes a hazard.
- Required stall depth D ∈ {0,1,2} is computed combinationally from the matches (see Configuration).
- FSM states:
  - IDLE: hazards are evaluated. If D≥1, stall this cycle. If D=2, also assert `stall_twice` and go to STALL1; otherwise stay in IDLE.
  - STALL1: stall for exactly one cycle without re-evaluating hazards, then go to IDLE.
- A stall cycle drives `PC_En`=0, `IF2ID_En`=0 and `ID2EXE_Flush`=1.
- A non-stall cycle drives `PC_En`=1, `IF2ID_En`=1 and both flushes 0.
- `ex_redirect` has highest priority in any state:
  - `PC_En`=1, `IF2ID_En`=1, `IF2ID_Flush`=1, `ID2EXE_Flush`=1, `stall_twice`=0.
  - Next state is IDLE, aborting any stall in progress.
  - `flush_count` increments.
- Counters:
  - `stall_cycles` increments in every cycle with `PC_En`=0.
  - Both counters saturate at all-ones and never wrap.
  - `perf_clr` zeroes both counters and takes priority over increment in the same cycle.

## Timing
- Outputs are combinational from state and inputs. Zero-cycle latency: a hazard seen in cycle N stalls in cycle N.
- D=1 gives exactly 1 stall cycle. D=2 gives exactly 2 consecutive stall cycles, with `stall_twice` high only in the first.
- `busy` is registered: high in the cycle following entry to STALL1.
- While `Reset`=1, all outputs take their reset values regardless of other inputs:
  - `PC_En`=1, `IF2ID_En`=1, `IF2ID_Flush`=0, `ID2EXE_Flush`=0, `stall_twice`=0, `busy`=0.
- At the first edge with `Reset`=1: state→IDLE and both counters→0.
- Reset asserted in the middle of a stall sequence abandons it: the next cycle is IDLE with no residual stall.
- Redirect in the same cycle as a hazard: the redirect wins, no stall, and `stall_cycles` does not increment.

## Configuration
- `FORWARDING_EN` defined (EX/MEM forwarding is present):
  - D=1 iff the EX instruction is a load (`ex_Mem_R_En`=1) matching a source; else D=0.
  - MEM matches are ignored; D=2 never occurs; `stall_twice` is never asserted.
- `FORWARDING_EN` undefined:
  - D=2 if an EX producer matches.
  - Otherwise D=1 if a MEM producer matches.
  - Otherwise D=0.
  - The register file is write-first, so WB never causes a hazard.

## Test plan
- Reset: hold `Reset` 2 cycles with `ex_redirect`=1 and a matching hazard applied → all outputs at reset values; counters 0 after release.
- No forwarding: `ex_rd`=5, `ex_Reg_W_En`=1, `id_rs1`=5, `id_use_rs1`=1 → `PC_En`=0 for 2 cycles, `stall_twice`=1 in the first only; `stall_cycles`=2.
- No forwarding, MEM only: `mem_rd`=7, `mem_Reg_W_En`=1, `id_rs2`=7 → 1 stall cycle; `stall_twice` stays 0. Same stimulus with rd=0 → no stall.
- `FORWARDING_EN`: load in EX to x3, `id_rs1`=3 → 1 stall cycle. Non-load EX producer to x3 → no stall.
- Redirect during STALL1: assert `ex_redirect` in the second stall cycle → both flushes 1, `PC_En`=1, next state IDLE, `flush_count`=1.
- Saturation: preload `stall_cycles` to all-ones (or use `STALL_CNT_W`=2), apply 5 stall cycles → value holds at max. Assert `perf_clr` during a stall cycle → 0 at the next edge.
